alu_seq_flags: RTL
==================

// Module: alu_seq_flags
// PURPOSE
//  Parametrised, clocked successor to the 32-bit combinational ALU.
//  - Accepts one operation per valid/ready handshake.
//  - Computes add/sub (with or without stored carry), compare and shift ops; shifts are iterative.
//  - Returns a registered result with Z/N/C/V/ERR flags over an output valid/ready handshake.
//  - Sits between the control unit (issues opcodes) and the register-file writeback.
// PARAMETERS
//  WIDTH       32  operand/result width, >= 4
//  SHIFT_STEP  1   max bit positions shifted per cycle, 1..WIDTH
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      a/b/op_code valid
//  in_ready   out  1      block can accept an op this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B / shift amount
//  op_code    in   6      operation select
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes result this cycle
//  result     out  WIDTH  registered result
//  z          out  1      result == 0
//  n          out  1      result[WIDTH-1]
//  c          out  1      stored carry/borrow flag
//  v          out  1      signed overflow of last add/sub
//  err        out  1      last op was an illegal opcode
// BEHAVIOUR
//  Reset (rst=1 at edge)
//  - state=IDLE; result, z, n, c, v, err, out_valid all 0.
//  - in_ready=0 while rst is high. Reset mid-shift abandons the op; no output is produced.
//  Accept and handshake
//  - An op is accepted when in_valid && in_ready.
//  - in_ready = !rst && (state==IDLE || (state==DONE && out_ready)), so back-to-back ops are allowed.
//  - In DONE, result and flags are held stable until out_ready=1. Then:
//    - in_valid=1: the next op is accepted in the same cycle.
//    - in_valid=0: go to IDLE and drop out_valid.
//  Opcodes
//  - Add/sub, all operands unsigned, arithmetic modulo 2^WIDTH:
//    - 010000 ADC: a+b+c
//    - 010001 SBC: a-b-c
//    - 010010 ADD: a+b
//    - 010011 SUB: a-b
//  - Compares, unsigned, result is 1 or 0:
//    - 100000 EQ, 100001 NE, 100010 LE (a<=b), 100011 GT (a>b)
//  - Shifts:
//    - 110000 SLL, 110001 SRL, 110010 SRA (sign fill from a[WIDTH-1])
//    - shift count k = min(b, WIDTH), using the full b width.
//    - k=WIDTH gives SLL/SRL=0 and SRA=all sign bits.
//  - Any other opcode: result=0, err=1, c and v unchanged.
//  - Every legal op clears err.
//  Flags
//  - c and v update only on ADC/SBC/ADD/SUB:
//    - add: c = carry out of bit WIDTH-1.
//    - sub: c = borrow = (a < b+bin), computed at WIDTH+1 bits.
//    - v = signed overflow.
//  - Compares and shifts leave c and v unchanged.
//  - z and n are computed from the final result for every op, including illegal ones.
//  - c is updated at the same edge the result registers, so an ADC accepted in the DONE-pop cycle sees the new c.
//  FSM: IDLE, SHIFT, DONE
//  - Non-shift op, or shift with k=0: result registers at the accept edge, go to DONE. out_valid is seen 1 cycle after accept.
//  - Shift with k>0: load a and k, go to SHIFT.
//  - In SHIFT: each cycle shift by min(rem, SHIFT_STEP) and decrement rem by the same amount. When rem reaches 0, go to DONE.
//  - Shift latency = 1 + ceil(k/SHIFT_STEP) cycles from accept to out_valid.
//  - in_ready=0 throughout SHIFT. Inputs are ignored during SHIFT.
// TESTING
//  1 rst held 2 cycles -> all outputs 0, in_ready=0. Release -> in_ready=1.
//  2 ADD a=FFFFFFFF, b=1 -> next cycle out_valid=1, result=0, z=1, c=1, v=0.
//    Then ADC a=1, b=1 -> result=3, c=0.
//  3 SUB a=80000000, b=1 -> result=7FFFFFFF, v=1, c=0.
//    SUB a=1, b=2 -> result=FFFFFFFF, n=1, c=1.
//  4 SRA a=80000000, b=4, SHIFT_STEP=1 -> out_valid exactly 5 cycles after accept, result=F8000000, in_ready=0 meanwhile.
//    SLL b=40 -> result=0 after 33 cycles.
//  5 Backpressure: out_ready=0 for 3 cycles -> result/flags stable.
//    out_ready=1 with a new op valid -> pop and accept in the same cycle, next result 1 cycle later.
//  6 op_code=111111 -> result=0, z=1, err=1, c unchanged.
//    rst asserted mid-shift -> IDLE next cycle, no out_valid.

Source files
------------

// File: rtl/alu_seq_flags.sv
// Clocked ALU with valid/ready handshakes on both sides: add/sub with stored carry,
// unsigned compares, and iterative shifts, returning a registered result with Z/N/C/V/ERR.
module alu_seq_flags #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       op_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v,
  output logic             err
);

  localparam int KW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WIDTH_B = WIDTH'(WIDTH);
  localparam logic [KW-1:0]    WIDTH_K = KW'(WIDTH);
  localparam logic [KW-1:0]    STEP_K  = KW'(SHIFT_STEP);

  localparam logic [5:0] OP_ADC = 6'b010000;
  localparam logic [5:0] OP_SBC = 6'b010001;
  localparam logic [5:0] OP_ADD = 6'b010010;
  localparam logic [5:0] OP_SUB = 6'b010011;
  localparam logic [5:0] OP_EQ  = 6'b100000;
  localparam logic [5:0] OP_NE  = 6'b100001;
  localparam logic [5:0] OP_LE  = 6'b100010;
  localparam logic [5:0] OP_GT  = 6'b100011;
  localparam logic [5:0] OP_SLL = 6'b110000;
  localparam logic [5:0] OP_SRL = 6'b110001;
  localparam logic [5:0] OP_SRA = 6'b110010;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_q;
  logic [KW-1:0]    rem_q;
  logic [1:0]       sh_kind_q;

  logic             accept;
  logic [KW-1:0]    k_in;
  logic [WIDTH-1:0] op_res;
  logic             op_c;
  logic             op_v;
  logic             op_err;
  logic             go_shift;
  logic [KW-1:0]    step;
  logic [KW-1:0]    rem_nxt;
  logic [WIDTH-1:0] sh_nxt;

  // Returns {v, c, sum}; the borrow of a subtract falls out as bit WIDTH of the
  // (WIDTH+1)-bit difference.
  function automatic logic [WIDTH+1:0] addsub(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic             sub,
                                              input logic             cin);
    logic [WIDTH:0] r;
    logic           ov;
    if (sub) begin
      r  = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, cin};
      ov = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    end else begin
      r  = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
      ov = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    end
    return {ov, r};
  endfunction

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] x,
                                                input logic [1:0]       kind,
                                                input logic [KW-1:0]    amt);
    logic signed [WIDTH-1:0] xs;
    xs = x;
    case (kind)
      2'b00:   return x << amt;
      2'b01:   return x >> amt;
      2'b10:   return xs >>> amt;
      default: return x;
    endcase
  endfunction

  assign in_ready = !rst && (state == IDLE || (state == DONE && out_ready));
  assign accept   = in_valid && in_ready;
  assign k_in     = (b >= WIDTH_B) ? WIDTH_K : b[KW-1:0];

  always_comb begin
    op_res   = '0;
    op_c     = c;
    op_v     = v;
    op_err   = 1'b0;
    go_shift = 1'b0;
    case (op_code)
      OP_ADC: {op_v, op_c, op_res} = addsub(a, b, 1'b0, c);
      OP_SBC: {op_v, op_c, op_res} = addsub(a, b, 1'b1, c);
      OP_ADD: {op_v, op_c, op_res} = addsub(a, b, 1'b0, 1'b0);
      OP_SUB: {op_v, op_c, op_res} = addsub(a, b, 1'b1, 1'b0);
      OP_EQ:  op_res = {{(WIDTH-1){1'b0}}, a == b};
      OP_NE:  op_res = {{(WIDTH-1){1'b0}}, a != b};
      OP_LE:  op_res = {{(WIDTH-1){1'b0}}, a <= b};
      OP_GT:  op_res = {{(WIDTH-1){1'b0}}, a > b};
      OP_SLL, OP_SRL, OP_SRA: begin
        if (k_in == '0) op_res = a;
        else            go_shift = 1'b1;
      end
      default: op_err = 1'b1;
    endcase
  end

  always_comb begin
    step    = (rem_q < STEP_K) ? rem_q : STEP_K;
    rem_nxt = rem_q - step;
    sh_nxt  = shift_by(sh_q, sh_kind_q, step);
  end

  // Control and architectural outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      z         <= 1'b0;
      n         <= 1'b0;
      c         <= 1'b0;
      v         <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            err <= op_err;
            c   <= op_c;
            v   <= op_v;
            if (go_shift) begin
              state     <= SHIFT;
              out_valid <= 1'b0;
            end else begin
              result    <= op_res;
              z         <= (op_res == '0);
              n         <= op_res[WIDTH-1];
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        SHIFT: begin
          if (rem_nxt == '0) begin
            result    <= sh_nxt;
            z         <= (sh_nxt == '0);
            n         <= sh_nxt[WIDTH-1];
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Shift working registers carry no reset; they are loaded on every shift accept
  always_ff @(posedge clk) begin
    if (accept && go_shift) begin
      sh_q      <= a;
      rem_q     <= k_in;
      sh_kind_q <= op_code[1:0];
    end else if (state == SHIFT) begin
      sh_q  <= sh_nxt;
      rem_q <= rem_nxt;
    end
  end

endmodule
